// File: rtl/add_sub_seq_if.sv
// add_sub_seq_if: operand/result handshake bundle for add_sub_seq.
// master drives operands and out_ready; slave (the adder) drives results.
interface add_sub_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [4:0]       flags;

    modport master (
        output in_valid, a, b, sub, out_ready,
        input  in_ready, out_valid, y, flags
    );

    modport slave (
        input  in_valid, a, b, sub, out_ready,
        output in_ready, out_valid, y, flags
    );
endinterface

// File: rtl/add_sub_seq.sv
// add_sub_seq: chunk-serial adder/subtractor. It adds CHUNK bits per cycle,
// LSB slice first, and reports {sat, N, V, C, Z} with a valid/ready handshake.
// Define ADD_SUB_SEQ_SAT_EN to clamp y to the signed range on overflow.
module add_sub_seq #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CHUNK = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    add_sub_seq_if.slave       bus
);
    localparam int unsigned NCH = WIDTH / CHUNK;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCH - 1);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic             carry;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] sum_r;
    logic             a_sign;
    logic             b_sign;

    logic [CHUNK:0]       slice_sum;
    logic [WIDTH+CHUNK:0] ext_unused_guard;
    logic [WIDTH-1:0]     next_sum;
    logic                 raw_v;
    logic [WIDTH-1:0]     final_y;
    logic                 sat_bit;

    // Slice adder and the result/flag values to commit after the last slice.
    // Finished slices enter sum_r from the top, so after NCH shifts the
    // whole result sits in place without a variable-index write.
    always_comb begin
        slice_sum        = {1'b0, a_r[CHUNK-1:0]} + {1'b0, b_r[CHUNK-1:0]}
                         + {{CHUNK{1'b0}}, carry};
        ext_unused_guard = {1'b0, slice_sum[CHUNK-1:0], sum_r};
        next_sum         = ext_unused_guard[WIDTH+CHUNK-1:CHUNK];
        raw_v            = (a_sign == b_sign) && (next_sum[WIDTH-1] != a_sign);
`ifdef ADD_SUB_SEQ_SAT_EN
        sat_bit = raw_v;
        if (raw_v) begin
            final_y = a_sign ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end else begin
            final_y = next_sum;
        end
`else
        sat_bit = 1'b0;
        final_y = next_sum;
`endif
    end

    // Control FSM with registered handshake, result and flag outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            carry         <= 1'b0;
            a_r           <= '0;
            b_r           <= '0;
            sum_r         <= '0;
            a_sign        <= 1'b0;
            b_sign        <= 1'b0;
            bus.in_ready  <= 1'b1;
            bus.out_valid <= 1'b0;
            bus.y         <= '0;
            bus.flags     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_r          <= bus.a;
                        b_r          <= bus.sub ? ~bus.b : bus.b;
                        carry        <= bus.sub;
                        a_sign       <= bus.a[WIDTH-1];
                        b_sign       <= bus.sub ? ~bus.b[WIDTH-1] : bus.b[WIDTH-1];
                        sum_r        <= '0;
                        cnt          <= '0;
                        bus.in_ready <= 1'b0;
                        state        <= CALC;
                    end
                end
                CALC: begin
                    a_r   <= a_r >> CHUNK;
                    b_r   <= b_r >> CHUNK;
                    sum_r <= next_sum;
                    carry <= slice_sum[CHUNK];
                    if (cnt == LAST) begin
                        bus.y         <= final_y;
                        bus.flags     <= {sat_bit, final_y[WIDTH-1], raw_v,
                                          slice_sum[CHUNK], (final_y == '0)};
                        bus.out_valid <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.in_ready  <= 1'b1;
                        cnt           <= '0;
                        state         <= IDLE;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    bus.in_ready  <= 1'b1;
                    state         <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_add_sub_seq.sv
// tb_add_sub_seq: directed vectors for add_sub_seq, including a 16/4 and a
// 32/32 instance for latency scaling. Expectations follow ADD_SUB_SEQ_SAT_EN.
module tb_add_sub_seq;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    add_sub_seq_if #(.WIDTH(32)) bus0 ();
    add_sub_seq_if #(.WIDTH(16)) bus1 ();
    add_sub_seq_if #(.WIDTH(32)) bus2 ();

    add_sub_seq #(.WIDTH(32), .CHUNK(8))  u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0.slave));
    add_sub_seq #(.WIDTH(16), .CHUNK(4))  u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
    add_sub_seq #(.WIDTH(32), .CHUNK(32)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One operation on the 32/8 instance; hold = cycles of backpressure in DONE.
    task automatic op0(input logic [31:0] av, input logic [31:0] bv, input logic sv,
                       input logic [31:0] ey, input logic [4:0] ef, input int hold,
                       input string tag);
        int n;
        @(negedge clk);
        bus0.a = av; bus0.b = bv; bus0.sub = sv;
        bus0.in_valid = 1'b1; bus0.out_ready = 1'b0;
        chk({tag, "_in_ready"}, 64'(bus0.in_ready), 64'd1);
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        bus0.a = 32'hDEAD_BEEF; bus0.b = 32'h1234_5678;
        n = 0;
        while (bus0.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk({tag, "_latency"}, 64'(n), 64'd4);
        chk({tag, "_y"}, 64'(bus0.y), 64'(ey));
        chk({tag, "_flags"}, 64'(bus0.flags), 64'(ef));
        for (int i = 0; i < hold; i++) begin
            bus0.in_valid = 1'b1;
            bus0.a = 32'h1111_0000 + 32'(i);
            @(posedge clk); #1;
            chk({tag, "_hold_valid"}, 64'(bus0.out_valid), 64'd1);
            chk({tag, "_hold_in_ready"}, 64'(bus0.in_ready), 64'd0);
            chk({tag, "_hold_y"}, 64'(bus0.y), 64'(ey));
            chk({tag, "_hold_flags"}, 64'(bus0.flags), 64'(ef));
        end
        bus0.in_valid = 1'b0;
        bus0.out_ready = 1'b1;
        @(posedge clk); #1;
        bus0.out_ready = 1'b0;
        chk({tag, "_drop_valid"}, 64'(bus0.out_valid), 64'd0);
        chk({tag, "_back_in_ready"}, 64'(bus0.in_ready), 64'd1);
        if (hold > 0) begin
            @(posedge clk); #1;
            chk({tag, "_idle_stays"}, 64'(bus0.in_ready), 64'd1);
        end
    endtask

    initial begin
        int  n;
        bit  seen;
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        bus0.in_valid = 1'b0; bus0.a = '0; bus0.b = '0; bus0.sub = 1'b0; bus0.out_ready = 1'b0;
        bus1.in_valid = 1'b0; bus1.a = '0; bus1.b = '0; bus1.sub = 1'b0; bus1.out_ready = 1'b0;
        bus2.in_valid = 1'b0; bus2.a = '0; bus2.b = '0; bus2.sub = 1'b0; bus2.out_ready = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("rst_y", 64'(bus0.y), 64'd0);
        chk("rst_flags", 64'(bus0.flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", 64'(bus0.in_ready), 64'd1);

        op0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 5'b00011, 0, "wrap");
`ifdef ADD_SUB_SEQ_SAT_EN
        op0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 5'b10100, 0, "pos_ovf");
        op0(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h8000_0000, 5'b11110, 0, "neg_ovf");
`else
        op0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 5'b01100, 0, "pos_ovf");
        op0(32'h8000_0000, 32'h8000_0000, 1'b0, 32'h0000_0000, 5'b00111, 0, "neg_ovf");
`endif
        op0(32'd5, 32'd7, 1'b1, 32'hFFFF_FFFE, 5'b01000, 0, "borrow");
        op0(32'd7, 32'd5, 1'b1, 32'h0000_0002, 5'b00010, 3, "noborrow_bp");
        op0(32'h00FF_00FF, 32'h0001_0001, 1'b0, 32'h0100_0100, 5'b00000, 0, "carry_chain");

        // Reset in the second CALC cycle discards the operation
        @(negedge clk);
        bus0.a = 32'd100; bus0.b = 32'd200; bus0.sub = 1'b0; bus0.in_valid = 1'b1;
        @(posedge clk); #1;
        bus0.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 64'(bus0.out_valid), 64'd0);
        chk("midrst_y", 64'(bus0.y), 64'd0);
        chk("midrst_flags", 64'(bus0.flags), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus0.out_valid !== 1'b0) seen = 1'b1;
        end
        chk("midrst_no_valid", 64'(seen), 64'd0);
        op0(32'd3, 32'd4, 1'b0, 32'd7, 5'b00000, 0, "after_rst");

        // WIDTH=16, CHUNK=4: 0x8000 - 0x0001
        @(negedge clk);
        bus1.a = 16'h8000; bus1.b = 16'h0001; bus1.sub = 1'b1; bus1.in_valid = 1'b1;
        @(posedge clk); #1;
        bus1.in_valid = 1'b0;
        n = 0;
        while (bus1.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("w16_latency", 64'(n), 64'd4);
`ifdef ADD_SUB_SEQ_SAT_EN
        chk("w16_y", 64'(bus1.y), 64'h8000);
        chk("w16_flags", 64'(bus1.flags), 64'(5'b11110));
`else
        chk("w16_y", 64'(bus1.y), 64'h7FFF);
        chk("w16_flags", 64'(bus1.flags), 64'(5'b00110));
`endif
        bus1.out_ready = 1'b1;
        @(posedge clk); #1;
        bus1.out_ready = 1'b0;
        chk("w16_drop_valid", 64'(bus1.out_valid), 64'd0);

        // WIDTH=32, CHUNK=32: single-cycle latency
        @(negedge clk);
        bus2.a = 32'd5; bus2.b = 32'd6; bus2.sub = 1'b0; bus2.in_valid = 1'b1;
        @(posedge clk); #1;
        bus2.in_valid = 1'b0;
        n = 0;
        while (bus2.out_valid !== 1'b1 && n < 20) begin
            @(posedge clk); #1; n++;
        end
        chk("c32_latency", 64'(n), 64'd1);
        chk("c32_y", 64'(bus2.y), 64'd11);
        chk("c32_flags", 64'(bus2.flags), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
